// File: rtl/tone_generator.sv
// tone_generator: square-wave tone from a half-period divider, with glitch-free
// divider updates at half boundaries and click-free stop after a full period.
module tone_generator #(
    parameter int DIV_W   = 15,
    parameter int MIN_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] frequency,
    output logic             tone_out,
    output logic             active,
    output logic             toggle_pulse
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
    logic [1:0]       state, state_n;
    logic [DIV_W-1:0] counter, counter_n, div_q, div_n;
    logic             tone_n, active_n, pulse_n;
    logic             valid, last;
    assign valid = frequency >= DIV_W'(MIN_DIV);
    assign last  = counter == div_q - DIV_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= '0;
            div_q        <= '0;
            tone_out     <= 1'b0;
            active       <= 1'b0;
            toggle_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            counter      <= counter_n;
            div_q        <= div_n;
            tone_out     <= tone_n;
            active       <= active_n;
            toggle_pulse <= pulse_n;
        end
    end
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = (enable && valid) ? HIGH : IDLE;
            HIGH:    state_n = last ? LOW : HIGH;
            LOW:     state_n = last ? ((enable && valid) ? HIGH : IDLE) : LOW;
            default: state_n = IDLE;
        endcase
    end
    // The divider is only sampled when a new half-period begins.
    always_comb begin
        counter_n = (state == IDLE || state_n != state) ? '0 : counter + DIV_W'(1);
        div_n     = (state_n == HIGH && state != HIGH) || (state == HIGH && last && valid)
                    ? frequency : div_q;
        tone_n    = state_n == HIGH;
        active_n  = state_n != IDLE;
        pulse_n   = tone_n != tone_out;
    end
endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: randomized and directed checks of tone_generator against a
// half-period countdown model, plus literal waveform timing expectations.
module tb_tone_generator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [14:0] frequency = '0;
    logic        tone_out, active, toggle_pulse;
    int checks = 0;
    int failures = 0;
    bit m_run, m_level, m_pulse;
    int m_rem, m_div;
    int runs[$];
    int run_len = 0;
    logic prev = 1'b0;
    int act_cnt = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    tone_generator dut (
        .clk(clk), .rst(rst), .enable(enable), .frequency(frequency),
        .tone_out(tone_out), .active(active), .toggle_pulse(toggle_pulse)
    );

    function automatic bit ok(int f);
        return f >= 2;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a running tone is a sequence of halves, each a level held for a
    // fixed number of cycles chosen when that half starts.
    task automatic model_step();
        if (rst) begin
            m_run = 0; m_level = 0; m_pulse = 0; m_div = 0;
        end else if (!m_run) begin
            m_pulse = 0;
            if (enable && ok(frequency)) begin
                m_run = 1; m_level = 1; m_div = frequency; m_rem = m_div; m_pulse = 1;
            end
        end else begin
            m_rem--;
            m_pulse = 0;
            if (m_rem == 0) begin
                if (m_level) begin
                    if (ok(frequency)) m_div = frequency;
                    m_level = 0; m_rem = m_div; m_pulse = 1;
                end else if (enable && ok(frequency)) begin
                    m_div = frequency; m_level = 1; m_rem = m_div; m_pulse = 1;
                end else m_run = 0;
            end
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("tone_out", tone_out, m_level);
            check("active", active, m_run);
            check("toggle_pulse", toggle_pulse, m_pulse);
            if (tone_out !== prev) begin
                runs.push_back(run_len);
                run_len = 1;
                prev = tone_out;
            end else run_len++;
            act_cnt += int'(active);
            pulse_cnt += int'(toggle_pulse);
        end
    endtask

    task automatic clear();
        runs.delete();
        act_cnt = 0;
        pulse_cnt = 0;
    endtask

    task automatic wait_rise(int max);
        bit seen = 0;
        for (int i = 0; i < max && !seen; i++) begin
            step(1);
            seen = (tone_out === 1'b1 && toggle_pulse === 1'b1);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_rise: no rising edge within %0d cycles", max);
        end
    endtask

    initial begin
        step(2);
        check("reset_tone", tone_out, 0);
        check("reset_active", active, 0);
        check("reset_pulse", toggle_pulse, 0);
        rst = 0; enable = 1; frequency = 4;
        step(1);
        check("start_tone", tone_out, 1);
        check("start_pulse", toggle_pulse, 1);
        clear();
        step(24);
        check("steady_runs", runs.size(), 6);
        check("steady_hi", runs[0], 4);
        check("steady_lo", runs[5], 4);
        check("steady_pulses", pulse_cnt, 6);
        check("steady_active", act_cnt, 24);

        wait_rise(20);
        clear();
        step(1);
        frequency = 6;
        step(16);
        check("chg_runs", runs.size(), 3);
        check("chg_hi_old", runs[0], 4);
        check("chg_lo_new", runs[1], 6);
        check("chg_hi_new", runs[2], 6);

        frequency = 5;
        wait_rise(20);
        clear();
        step(2);
        enable = 0;
        step(20);
        check("stop_runs", runs.size(), 1);
        check("stop_hi", runs[0], 5);
        check("stop_active_cycles", act_cnt, 9);
        check("stop_pulses", pulse_cnt, 1);
        check("stop_tone", tone_out, 0);
        check("stop_active", active, 0);

        enable = 1; frequency = 0;
        step(3);
        check("inv0_active", active, 0);
        check("inv0_tone", tone_out, 0);
        frequency = 1;
        step(3);
        check("inv1_active", active, 0);
        check("inv1_tone", tone_out, 0);
        frequency = 4;
        wait_rise(5);
        clear();
        step(3);
        frequency = 1;
        step(20);
        check("invb_runs", runs.size(), 1);
        check("invb_hi", runs[0], 4);
        check("invb_active_cycles", act_cnt, 7);
        check("invb_active", active, 0);

        frequency = 4;
        wait_rise(5);
        step(3);
        rst = 1;
        step(1);
        check("rstmid_tone", tone_out, 0);
        check("rstmid_active", active, 0);
        check("rstmid_pulse", toggle_pulse, 0);
        rst = 0;
        step(1);
        check("restart_tone", tone_out, 1);
        check("restart_pulse", toggle_pulse, 1);

        repeat (3000) begin
            rst = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 3) != 0);
            frequency = ($urandom_range(0, 4) == 0) ? 15'($urandom_range(0, 1))
                                                    : 15'($urandom_range(2, 9));
            step($urandom_range(1, 6));
        end

        rst = 1;
        step(1);
        rst = 0; enable = 1; frequency = 25000;
        step(1);
        check("full_start", tone_out, 1);
        clear();
        step(25100);
        frequency = 6250;
        step(62500 - 25100);
        check("full_runs", runs.size(), 4);
        check("full_hi", runs[0], 25000);
        check("full_lo", runs[1], 25000);
        check("fast_hi", runs[2], 6250);
        check("fast_lo", runs[3], 6250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
